softmax_in_loader: RTL and testbench
====================================

SOFTMAX_IN_LOADER -- requirements
Module: softmax_in_loader

Interface
- REQ-001: Parameter BEAT_W, default 257, is the stream beat width in bits.
- REQ-002: Parameter BEATS, default 4, is the number of beats per row word; BEATS*BEAT_W SHALL equal 1028.
- REQ-003: Parameter ADDR_W, default 8, is the BRAM address width.
- REQ-004: The block SHALL have one clock and an asynchronous, active-low reset:
  - i_clk  in  1  clock; all logic on rising edge.
  - i_rst_n  in  1  asynchronous active-low reset.
- REQ-005: The stream input ports SHALL be:
  - i_depth  in  8  rows per frame; sampled on the first beat of a frame.
  - i_s_valid  in  1  upstream beat valid.
  - o_s_ready  out  1  loader accepts beat.
  - i_s_data  in  BEAT_W  beat payload.
  - i_s_last  in  1  final beat of the frame.
- REQ-006: The softmax_core control and write-port outputs SHALL be:
  - o_ext_cena  out  1  write-port chip enable to softmax_core.
  - o_ext_wea  out  1  write-port write enable.
  - o_ext_addra  out  ADDR_W  write address.
  - o_ext_dina  out  1028  packed row word.
  - o_start  out  1  one-cycle start pulse to softmax_core.
  - i_busy  in  1  softmax_core busy.
- REQ-007: The status outputs SHALL be:
  - o_done  out  1  one-cycle pulse when the frame has been processed.
  - o_err  out  1  sticky framing or timeout error flag.

Function
- REQ-008: The FSM states SHALL be IDLE, FILL, WRITE, START, WAIT_HI, WAIT_LO.
- REQ-009: In IDLE, o_s_ready SHALL be 1 when i_depth != 0 and 0 otherwise.
- REQ-010: In IDLE, the first accepted beat SHALL latch i_depth, clear o_err, clear the row counter, and move to FILL.
- REQ-011: Beat k of a row (k = 0..BEATS-1) SHALL be stored into bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k] of the packing register.
- REQ-012: In FILL, o_s_ready SHALL be 1; acceptance of beat BEATS-1 SHALL move to WRITE.
- REQ-013: WRITE SHALL last exactly one cycle with o_ext_cena=1, o_ext_wea=1, o_ext_addra=row counter, o_ext_dina=packed word, and o_s_ready=0.
- REQ-014: o_ext_cena and o_ext_wea SHALL be 0 in every other state.
- REQ-015: After WRITE, the row counter SHALL increment; if the rows written equal the latched depth, go to START, else go to FILL.
- REQ-016: Steady-state throughput SHALL be BEATS+1 cycles per row when i_s_valid is held high.
- REQ-017: START SHALL drive o_start=1 for exactly one cycle, then go to WAIT_HI.
- REQ-018: WAIT_HI SHALL go to WAIT_LO when i_busy=1.
- REQ-019: WAIT_LO SHALL go to IDLE when i_busy=0 and pulse o_done for one cycle.
- REQ-020: o_s_ready SHALL be 0 in START, WAIT_HI and WAIT_LO.
- REQ-021: i_s_last asserted on an accepted beat that is not beat BEATS-1 of row depth-1 (early last) SHALL set o_err, discard the partial frame, return to IDLE, and produce no o_start.
- REQ-022: i_s_last low on the final beat of the frame (missing last) SHALL set o_err; the frame SHALL still be written and started normally.
- REQ-023: Changes on i_depth after a frame starts SHALL be ignored until the next IDLE.
- REQ-024: Beats presented while o_s_ready=0 SHALL NOT be consumed.
- REQ-025: The row address SHALL run from 0 to depth-1 with no wrap; the maximum depth of 255 uses addresses 0..254.

Reset
- REQ-026: Asserting i_rst_n low at any time SHALL immediately force IDLE and clear every output, the packing register, the row counter and the beat counter to 0.
- REQ-027: A partial row or frame in progress at reset SHALL be discarded, and no write or start SHALL occur after reset release without new beats.

Configuration
- REQ-028: With macro SOFTMAX_LOADER_TIMEOUT_EN defined, a 16-bit watchdog SHALL count cycles in WAIT_HI and WAIT_LO.
- REQ-029: With the watchdog compiled in, more than 1024 cycles in WAIT_HI, or a count reaching 65535 in WAIT_LO, SHALL set o_err and return to IDLE without o_done.
- REQ-030: With SOFTMAX_LOADER_TIMEOUT_EN undefined, no watchdog SHALL exist and WAIT_HI/WAIT_LO SHALL wait indefinitely.

Verification
- REQ-031: Depth=17, 68 beats with continuous valid, last on beat 68 -> 17 one-cycle writes at addr 0..16 each holding the concatenated beats, one o_start, o_done after busy falls, o_err=0.
- REQ-032: Depth=2 with valid toggling every other cycle -> data packed correctly, no beat lost or duplicated, exactly 2 writes.
- REQ-033: Depth=3 with last on beat 6 -> o_err=1, no o_start, IDLE, and the next good frame clears o_err.
- REQ-034: Depth=0 with valid high -> o_s_ready stays 0 and no writes occur; reset asserted mid-row 5 of depth 17 -> all outputs 0 immediately and no subsequent write.
- REQ-035: With SOFTMAX_LOADER_TIMEOUT_EN defined and i_busy tied 0 after start -> o_err=1 after 1025 cycles in WAIT_HI and no o_done; with the macro undefined -> stays in WAIT_HI.

Source files
------------

// File: rtl/softmax_in_loader.sv
// Stream-to-BRAM loader for softmax_core: packs BEATS beats into one row word, writes each row, then starts the core.
// Optional build macro SOFTMAX_LOADER_TIMEOUT_EN adds a 16-bit busy-handshake watchdog.
module softmax_in_loader #(
    parameter int BEAT_W = 257,
    parameter int BEATS  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [7:0]                i_depth,
    input  logic                      i_s_valid,
    output logic                      o_s_ready,
    input  logic [BEAT_W-1:0]         i_s_data,
    input  logic                      i_s_last,
    output logic                      o_ext_cena,
    output logic                      o_ext_wea,
    output logic [ADDR_W-1:0]         o_ext_addra,
    output logic [BEATS*BEAT_W-1:0]   o_ext_dina,
    output logic                      o_start,
    input  logic                      i_busy,
    output logic                      o_done,
    output logic                      o_err
);

    typedef enum logic [2:0] {IDLE, FILL, WRITE, START, WAIT_HI, WAIT_LO} state_t;

    localparam int BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    state_t                       state;
    logic [7:0]                   depth_q;
    logic [7:0]                   row_cnt;
    logic [BC_W-1:0]              beat_cnt;
    logic [BEATS-1:0][BEAT_W-1:0] pack;

    logic       accept;
    logic       row_end;
    logic       frame_end;
    logic [7:0] depth_eff;
    logic [7:0] row_eff;

`ifdef SOFTMAX_LOADER_TIMEOUT_EN
    localparam logic [15:0] WD_HI_LIMIT = 16'd1024;
    logic [15:0] wd_cnt;
`endif

    // In IDLE the frame has not been latched yet, so the live depth and row 0 decide framing.
    always_comb begin
        depth_eff = (state == IDLE) ? i_depth : depth_q;
        row_eff   = (state == IDLE) ? 8'd0 : row_cnt;
        o_s_ready = i_rst_n && (((state == IDLE) && (i_depth != 8'd0)) || (state == FILL));
        accept    = i_s_valid && o_s_ready;
        row_end   = (beat_cnt == LAST_BEAT);
        frame_end = row_end && (row_eff == depth_eff - 8'd1);
    end

    assign o_ext_dina = pack;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            depth_q     <= '0;
            row_cnt     <= '0;
            beat_cnt    <= '0;
            // NOTE: the packing register is reset too, so no stale row can ever reach the write port.
            pack        <= '0;
            o_ext_cena  <= 1'b0;
            o_ext_wea   <= 1'b0;
            o_ext_addra <= '0;
            o_start     <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            // NOTE: non-blocking defaults make every strobe a one-cycle pulse; a later assignment in the same cycle wins.
            o_ext_cena <= 1'b0;
            o_ext_wea  <= 1'b0;
            o_start    <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        pack[beat_cnt] <= i_s_data;
                        if (state == IDLE) begin
                            depth_q <= i_depth;
                            row_cnt <= '0;
                            o_err   <= 1'b0;
                        end
                        if (i_s_last && !frame_end) begin
                            o_err    <= 1'b1;
                            beat_cnt <= '0;
                            row_cnt  <= '0;
                            state    <= IDLE;
                        end else if (row_end) begin
                            beat_cnt    <= '0;
                            o_ext_cena  <= 1'b1;
                            o_ext_wea   <= 1'b1;
                            o_ext_addra <= ADDR_W'(row_eff);
                            state       <= WRITE;
                            if (frame_end && !i_s_last) o_err <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            state    <= FILL;
                        end
                    end
                end
                WRITE: begin
                    row_cnt <= row_cnt + 8'd1;
                    if (({1'b0, row_cnt} + 9'd1) == {1'b0, depth_q}) begin
                        o_start <= 1'b1;
                        state   <= START;
                    end else begin
                        state <= FILL;
                    end
                end
                START: begin
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
                    if (i_busy) begin
                        wd_cnt <= '0;
                        state  <= WAIT_LO;
                    end else if (wd_cnt == WD_HI_LIMIT) begin
                        o_err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`else
                    if (i_busy) state <= WAIT_LO;
`endif
                end
                WAIT_LO: begin
                    if (!i_busy) begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
                    else if (wd_cnt == 16'hFFFF) begin
                        o_err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_in_loader.sv
// Self-checking bench for softmax_in_loader: table-driven frames, random frames against a row-level model,
// and hand sequences for depth 0, depth changes, watchdog behaviour and reset mid-frame.
module tb_softmax_in_loader;

    localparam int BW = 257;
    localparam int NB = 4;
    localparam int AW = 8;
    localparam int WW = BW * NB;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic [7:0]    i_depth = 8'd0;
    logic          i_s_valid = 1'b0;
    logic          o_s_ready;
    logic [BW-1:0] i_s_data = '0;
    logic          i_s_last = 1'b0;
    logic          o_ext_cena;
    logic          o_ext_wea;
    logic [AW-1:0] o_ext_addra;
    logic [WW-1:0] o_ext_dina;
    logic          o_start;
    logic          i_busy = 1'b0;
    logic          o_done;
    logic          o_err;

    softmax_in_loader #(.BEAT_W(BW), .BEATS(NB), .ADDR_W(AW)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_depth    (i_depth),
        .i_s_valid  (i_s_valid),
        .o_s_ready  (o_s_ready),
        .i_s_data   (i_s_data),
        .i_s_last   (i_s_last),
        .o_ext_cena (o_ext_cena),
        .o_ext_wea  (o_ext_wea),
        .o_ext_addra(o_ext_addra),
        .o_ext_dina (o_ext_dina),
        .o_start    (o_start),
        .i_busy     (i_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int depth;
        int n_beats;
        int last_idx;
        int mode;
        int exp_rows;
        bit exp_start;
        bit exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] beats [0:1023];
    logic [AW-1:0] wr_addr[$];
    logic [WW-1:0] wr_data[$];
    longint        wr_time[$];
    int            wr_bad = 0;
    int            start_cyc = 0;
    int            done_cyc = 0;

    // Outputs are registered, so sampling on the falling edge sees each one-cycle pulse exactly once.
    always @(negedge i_clk) begin
        if (o_ext_cena) begin
            wr_addr.push_back(o_ext_addra);
            wr_data.push_back(o_ext_dina);
            wr_time.push_back($time);
            if (!o_ext_wea || o_s_ready) wr_bad++;
        end
        if (o_ext_wea && !o_ext_cena) wr_bad++;
        if (o_start) start_cyc++;
        if (o_done) done_cyc++;
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_time.delete();
        wr_bad    = 0;
        start_cyc = 0;
        done_cyc  = 0;
    endtask

    task automatic fill_beats(input int n);
        for (int i = 0; i < n; i++)
            beats[i] = {1'($urandom), $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
    endtask

    // Reference model: a frame either completes (all rows written, start issued) or is cut by an
    // early last, in which case only rows whose four beats preceded the offending beat are written.
    task automatic model(input int depth, input int last_idx, output int rows, output bit start, output bit err);
        int tot;
        tot = depth * NB;
        if (last_idx >= 0 && last_idx < tot - 1) begin
            rows  = last_idx / NB;
            start = 1'b0;
            err   = 1'b1;
        end else begin
            rows  = depth;
            start = 1'b1;
            err   = (last_idx != tot - 1);
        end
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid.
    task automatic drive_frame(input int depth, input int n, input int last_idx, input int mode, input bit scramble);
        int i;
        int guard;
        bit v;
        i = 0;
        guard = 0;
        i_depth = 8'(depth);
        while (i < n && guard < 20000) begin
            tick();
            guard++;
            if (scramble && i > 0) i_depth = 8'($urandom_range(0, 255));
            case (mode)
                0:       v = 1'b1;
                1:       v = guard[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            i_s_valid = v;
            i_s_data  = beats[i];
            i_s_last  = (i == last_idx);
            #1;
            if (v && o_s_ready) i++;
        end
        tick();
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
        check("beats_accepted", i, n);
    endtask

    task automatic finish_frame(input bit exp_start, input bit exp_err);
        int w;
        w = 0;
        if (exp_start) begin
            while (start_cyc == 0 && w < 50) begin
                tick();
                w++;
            end
            repeat ($urandom_range(1, 4)) tick();
            i_busy = 1'b1;
            repeat ($urandom_range(1, 6)) tick();
            i_busy = 1'b0;
            w = 0;
            while (done_cyc == 0 && w < 50) begin
                tick();
                w++;
            end
            tick();
            check("start_pulse_cycles", start_cyc, 1);
            check("done_pulse_cycles", done_cyc, 1);
        end else begin
            repeat (10) tick();
            check("no_start", start_cyc, 0);
            check("no_done", done_cyc, 0);
        end
        check("err_flag", o_err, exp_err);
    endtask

    task automatic run_frame(input int depth, input int n, input int last_idx, input int mode, input bit scramble,
                             input int exp_rows, input bit exp_start, input bit exp_err);
        logic [WW-1:0] w;
        clear_mon();
        fill_beats(n);
        drive_frame(depth, n, last_idx, mode, scramble);
        finish_frame(exp_start, exp_err);
        check("n_writes", wr_addr.size(), exp_rows);
        check("write_strobes", wr_bad, 0);
        for (int r = 0; r < wr_addr.size() && r < exp_rows; r++) begin
            check("write_addr", wr_addr[r], r);
            w = wr_data[r];
            for (int k = 0; k < NB; k++) check("write_beat", w[k*BW +: BW], beats[r*NB + k]);
            if (mode == 0 && r > 0) check("row_period", wr_time[r] - wr_time[r-1], 50);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    vec_t vecs[10];

    initial begin
        int ready_seen;
        int rows;
        bit st;
        bit er;
        int depth;
        int kind;
        int tot;
        int last;
        int n;
        logic [WW-1:0] w;

        vecs[0] = '{17, 68, 67, 0, 17, 1'b1, 1'b0};
        vecs[1] = '{2, 8, 7, 1, 2, 1'b1, 1'b0};
        vecs[2] = '{3, 6, 5, 0, 1, 1'b0, 1'b1};
        vecs[3] = '{1, 4, 3, 2, 1, 1'b1, 1'b0};
        vecs[4] = '{2, 8, -1, 0, 2, 1'b1, 1'b1};
        vecs[5] = '{3, 12, 11, 2, 3, 1'b1, 1'b0};
        vecs[6] = '{2, 1, 0, 0, 0, 1'b0, 1'b1};
        vecs[7] = '{4, 12, 11, 0, 2, 1'b0, 1'b1};
        vecs[8] = '{1, 4, 3, 1, 1, 1'b1, 1'b0};
        vecs[9] = '{255, 1020, 1019, 0, 255, 1'b1, 1'b0};

        // Reset state, with a nonzero depth so an ungated ready would show.
        i_depth = 8'd5;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_ready", o_s_ready, 0);
        check("rst_cena", o_ext_cena, 0);
        check("rst_wea", o_ext_wea, 0);
        check("rst_addr", o_ext_addra, 0);
        check("rst_dina_lo", o_ext_dina[BW-1:0], 0);
        check("rst_start", o_start, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check("idle_ready_depth_nonzero", o_s_ready, 1);

        for (int v = 0; v < 10; v++)
            run_frame(vecs[v].depth, vecs[v].n_beats, vecs[v].last_idx, vecs[v].mode, 1'b0,
                      vecs[v].exp_rows, vecs[v].exp_start, vecs[v].exp_err);

        // Depth 0 must hold off the stream entirely.
        clear_mon();
        i_depth = 8'd0;
        i_s_valid = 1'b1;
        i_s_data = '1;
        ready_seen = 0;
        repeat (20) begin
            tick();
            if (o_s_ready) ready_seen++;
        end
        i_s_valid = 1'b0;
        tick();
        check("depth0_ready", ready_seen, 0);
        check("depth0_writes", wr_addr.size(), 0);

        // Depth changes mid-frame are ignored.
        run_frame(5, 20, 19, 2, 1'b1, 5, 1'b1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            depth = $urandom_range(1, 6);
            tot = depth * NB;
            kind = $urandom_range(0, 2);
            last = (kind == 0) ? tot - 1 : (kind == 1) ? -1 : $urandom_range(0, tot - 2);
            n = (kind == 2) ? last + 1 : tot;
            model(depth, last, rows, st, er);
            run_frame(depth, n, last, $urandom_range(0, 2), 1'b0, rows, st, er);
        end

        // Busy never rises after start.
        clear_mon();
        fill_beats(4);
        drive_frame(1, 4, 3, 0, 1'b0);
        repeat (1100) tick();
        check("wd_writes", wr_addr.size(), 1);
        check("wd_start", start_cyc, 1);
        check("wd_no_done", done_cyc, 0);
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
        check("wd_err", o_err, 1);
        check("wd_back_idle", o_s_ready, 1);
`else
        check("wd_err", o_err, 0);
        check("wd_still_waiting", o_s_ready, 0);
`endif

        // Clean reset, then reset in the middle of row 5 of a depth-17 frame.
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        clear_mon();
        fill_beats(68);
        drive_frame(17, 22, -1, 0, 1'b0);
        check("pre_rst_writes", wr_addr.size(), 5);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_ready", o_s_ready, 0);
        check("midrst_cena", o_ext_cena, 0);
        check("midrst_wea", o_ext_wea, 0);
        check("midrst_addr", o_ext_addra, 0);
        w = o_ext_dina;
        for (int k = 0; k < NB; k++) check("midrst_dina", w[k*BW +: BW], 0);
        check("midrst_start", o_start, 0);
        check("midrst_done", o_done, 0);
        check("midrst_err", o_err, 0);
        tick();
        tick();
        i_rst_n = 1'b1;
        clear_mon();
        repeat (30) tick();
        check("post_rst_writes", wr_addr.size(), 0);
        check("post_rst_start", start_cyc, 0);

        run_frame(2, 8, 7, 0, 1'b0, 2, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
